// File: rtl/fpu_check_pkg.sv
// rtl/fpu_check_pkg.sv - shared checker state type and NaN classifier
package fpu_check_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} chk_state_t;

   localparam int MAX_W = 128;

   // Operand is zero-extended into MAX_W bits; width/exp_w select the field boundaries.
   function automatic logic is_nan(input logic [MAX_W-1:0] v, input int width, input int exp_w);
      logic exp_ones;
      logic mant_nz;
      exp_ones = 1'b1;
      mant_nz  = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width - 1 - exp_w) mant_nz = mant_nz | v[i];
         else if (i < width - 1)    exp_ones = exp_ones & v[i];
      end
      return exp_ones & mant_nz;
   endfunction

endpackage

// File: rtl/fpu_lockstep_checker_delay.sv
// rtl/fpu_lockstep_checker_delay.sv - fixed-depth shift register, plain wire at depth 0
module chk_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rstn;
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end
         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/fpu_lockstep_checker.sv
// rtl/fpu_lockstep_checker.sv - aligns two FPU result streams and records disagreements
module fpu_lockstep_checker
   import fpu_check_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EXP_W       = 8,
   parameter int LAT_A       = 7,
   parameter int LAT_B       = 7,
   parameter int NAN_EQ      = 0,
   parameter int STOP_ON_ERR = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_x1,
   input  logic [WIDTH-1:0] in_x2,
   input  logic [WIDTH-1:0] res_a,
   input  logic [WIDTH-1:0] res_b,
   input  logic             start,
   input  logic             clear,
   output logic             running,
   output logic             err,
   output logic [CNT_W-1:0] check_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic             cap_valid,
   output logic [WIDTH-1:0] cap_x1,
   output logic [WIDTH-1:0] cap_x2,
   output logic [WIDTH-1:0] cap_b,
   output logic [WIDTH-1:0] cap_a
);

   localparam int LMAX = (LAT_A > LAT_B) ? LAT_A : LAT_B;
   localparam int OPW  = 1 + 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [OPW-1:0]   op_d;
   logic             v_d;
   logic [WIDTH-1:0] x1_d, x2_d, ra_d, rb_d;

   // Operands wait the full LMAX; each result waits only the remainder of its own latency.
   chk_delay #(.WIDTH(OPW), .DEPTH(LMAX)) u_op_dly (
      .clk(clk), .rstn(rstn), .din({in_valid, in_x1, in_x2}), .dout(op_d));
   chk_delay #(.WIDTH(WIDTH), .DEPTH(LMAX - LAT_A)) u_a_dly (
      .clk(clk), .rstn(rstn), .din(res_a), .dout(ra_d));
   chk_delay #(.WIDTH(WIDTH), .DEPTH(LMAX - LAT_B)) u_b_dly (
      .clk(clk), .rstn(rstn), .din(res_b), .dout(rb_d));

   assign {v_d, x1_d, x2_d} = op_d;

   chk_state_t state;
   logic       do_cmp, both_nan, hit;

   assign do_cmp   = v_d && (state == RUN);
   assign both_nan = (NAN_EQ != 0) && is_nan(MAX_W'(ra_d), WIDTH, EXP_W)
                                   && is_nan(MAX_W'(rb_d), WIDTH, EXP_W);
   assign hit      = do_cmp && (ra_d != rb_d) && !both_nan;
   assign running  = (state == RUN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         check_cnt    <= '0;
         mismatch_cnt <= '0;
         err          <= 1'b0;
         cap_valid    <= 1'b0;
         cap_x1       <= '0;
         cap_x2       <= '0;
         cap_b        <= '0;
         cap_a        <= '0;
      end else if (clear) begin
         state        <= IDLE;
         check_cnt    <= '0;
         mismatch_cnt <= '0;
         err          <= 1'b0;
         cap_valid    <= 1'b0;
         cap_x1       <= '0;
         cap_x2       <= '0;
         cap_b        <= '0;
         cap_a        <= '0;
      end else begin
         if (do_cmp && check_cnt != CNT_MAX) check_cnt <= check_cnt + 1'b1;
         if (hit) begin
            if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
            err <= 1'b1;
            if (!cap_valid) begin
               cap_valid <= 1'b1;
               cap_x1    <= x1_d;
               cap_x2    <= x2_d;
               cap_b     <= rb_d;
               cap_a     <= ra_d;
            end
         end
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (hit && STOP_ON_ERR != 0) state <= HALT;
            HALT:    if (start) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_lockstep_checker.sv
// tb/tb_fpu_lockstep_checker.sv - four checker configurations against an issue-history reference model
module tb_fpu_lockstep_checker;

   localparam int ND = 4;
   localparam int LA [ND] = '{7, 3, 7, 0};
   localparam int LB [ND] = '{7, 7, 7, 2};
   localparam int NQ [ND] = '{0, 1, 0, 0};
   localparam int SE [ND] = '{0, 0, 1, 0};
   localparam int CW [ND] = '{16, 16, 16, 4};

   logic        clk = 1'b0;
   logic        rstn, in_valid, start, clear;
   logic [31:0] in_x1, in_x2;
   logic [31:0] res_a [ND];
   logic [31:0] res_b [ND];

   logic        run0, run1, run2, run3, err0, err1, err2, err3;
   logic        capv0, capv1, capv2, capv3;
   logic [15:0] chk0, chk1, chk2, mis0, mis1, mis2;
   logic [3:0]  chk3, mis3;
   logic [31:0] cx1_0, cx1_1, cx1_2, cx1_3, cx2_0, cx2_1, cx2_2, cx2_3;
   logic [31:0] cb0, cb1, cb2, cb3, ca0, ca1, ca2, ca3;

   always #5 clk = ~clk;

   fpu_lockstep_checker #(.LAT_A(7), .LAT_B(7), .NAN_EQ(0), .STOP_ON_ERR(0), .CNT_W(16)) u0 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_x1(in_x1), .in_x2(in_x2),
      .res_a(res_a[0]), .res_b(res_b[0]), .start(start), .clear(clear), .running(run0), .err(err0),
      .check_cnt(chk0), .mismatch_cnt(mis0), .cap_valid(capv0), .cap_x1(cx1_0), .cap_x2(cx2_0),
      .cap_b(cb0), .cap_a(ca0));
   fpu_lockstep_checker #(.LAT_A(3), .LAT_B(7), .NAN_EQ(1), .STOP_ON_ERR(0), .CNT_W(16)) u1 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_x1(in_x1), .in_x2(in_x2),
      .res_a(res_a[1]), .res_b(res_b[1]), .start(start), .clear(clear), .running(run1), .err(err1),
      .check_cnt(chk1), .mismatch_cnt(mis1), .cap_valid(capv1), .cap_x1(cx1_1), .cap_x2(cx2_1),
      .cap_b(cb1), .cap_a(ca1));
   fpu_lockstep_checker #(.LAT_A(7), .LAT_B(7), .NAN_EQ(0), .STOP_ON_ERR(1), .CNT_W(16)) u2 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_x1(in_x1), .in_x2(in_x2),
      .res_a(res_a[2]), .res_b(res_b[2]), .start(start), .clear(clear), .running(run2), .err(err2),
      .check_cnt(chk2), .mismatch_cnt(mis2), .cap_valid(capv2), .cap_x1(cx1_2), .cap_x2(cx2_2),
      .cap_b(cb2), .cap_a(ca2));
   fpu_lockstep_checker #(.LAT_A(0), .LAT_B(2), .NAN_EQ(0), .STOP_ON_ERR(0), .CNT_W(4)) u3 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_x1(in_x1), .in_x2(in_x2),
      .res_a(res_a[3]), .res_b(res_b[3]), .start(start), .clear(clear), .running(run3), .err(err3),
      .check_cnt(chk3), .mismatch_cnt(mis3), .cap_valid(capv3), .cap_x1(cx1_3), .cap_x2(cx2_3),
      .cap_b(cb3), .cap_a(ca3));

   typedef struct {
      logic        run, err, capv;
      logic [15:0] chk, mis;
      logic [31:0] cx1, cx2, cb, ca;
   } obs_t;

   // Issue history: what was issued each cycle and what each unit eventually returns for it.
   logic        hv  [32];
   logic [31:0] hx1 [32];
   logic [31:0] hx2 [32];
   logic [31:0] hra [32];
   logic [31:0] hrb [32];
   int          cyc;

   int          m_st  [ND];
   int          m_chk [ND];
   int          m_mis [ND];
   logic        m_err [ND];
   logic        m_capv[ND];
   logic [31:0] m_cx1 [ND];
   logic [31:0] m_cx2 [ND];
   logic [31:0] m_cb  [ND];
   logic [31:0] m_ca  [ND];

   int nchk = 0;
   int nerr = 0;

   function automatic bit fnan(input logic [31:0] v);
      return (((v >> 23) & 32'hFF) == 32'hFF) && ((v & 32'h7FFFFF) != 0);
   endfunction

   function automatic obs_t get(input int k);
      obs_t o;
      case (k)
         0: begin o.run = run0; o.err = err0; o.capv = capv0; o.chk = chk0; o.mis = mis0;
                  o.cx1 = cx1_0; o.cx2 = cx2_0; o.cb = cb0; o.ca = ca0; end
         1: begin o.run = run1; o.err = err1; o.capv = capv1; o.chk = chk1; o.mis = mis1;
                  o.cx1 = cx1_1; o.cx2 = cx2_1; o.cb = cb1; o.ca = ca1; end
         2: begin o.run = run2; o.err = err2; o.capv = capv2; o.chk = chk2; o.mis = mis2;
                  o.cx1 = cx1_2; o.cx2 = cx2_2; o.cb = cb2; o.ca = ca2; end
         default: begin o.run = run3; o.err = err3; o.capv = capv3; o.chk = {12'h0, chk3};
                  o.mis = {12'h0, mis3}; o.cx1 = cx1_3; o.cx2 = cx2_3; o.cb = cb3; o.ca = ca3; end
      endcase
      return o;
   endfunction

   task automatic check(input string name, input int k, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endtask

   task automatic model_clear(input int k);
      m_st[k] = 0; m_chk[k] = 0; m_mis[k] = 0; m_err[k] = 0; m_capv[k] = 0;
      m_cx1[k] = 0; m_cx2[k] = 0; m_cb[k] = 0; m_ca[k] = 0;
   endtask

   // Effect of the coming clock edge on configuration k, from the op issued LMAX cycles ago.
   task automatic model_edge(input int k, input logic st, input logic cl);
      int lmax;
      int s;
      bit cmp;
      bit mm;
      int maxc;
      lmax = (LA[k] > LB[k]) ? LA[k] : LB[k];
      s    = (cyc - lmax) % 32;
      cmp  = hv[s] && (m_st[k] == 1) && !cl;
      mm   = (hra[s] != hrb[s]) && !(NQ[k] != 0 && fnan(hra[s]) && fnan(hrb[s]));
      maxc = (1 << CW[k]) - 1;
      if (cl) begin
         model_clear(k);
      end else begin
         if (cmp && m_chk[k] < maxc) m_chk[k]++;
         if (cmp && mm) begin
            if (m_mis[k] < maxc) m_mis[k]++;
            m_err[k] = 1;
            if (!m_capv[k]) begin
               m_capv[k] = 1; m_cx1[k] = hx1[s]; m_cx2[k] = hx2[s]; m_cb[k] = hrb[s]; m_ca[k] = hra[s];
            end
         end
         if ((m_st[k] == 0 || m_st[k] == 2) && st) m_st[k] = 1;
         else if (m_st[k] == 1 && cmp && mm && SE[k] != 0) m_st[k] = 2;
      end
   endtask

   task automatic check_all();
      obs_t o;
      for (int k = 0; k < ND; k++) begin
         o = get(k);
         check("running", k, o.run, m_st[k] == 1);
         check("err", k, o.err, m_err[k]);
         check("check_cnt", k, o.chk, m_chk[k]);
         check("mismatch_cnt", k, o.mis, m_mis[k]);
         check("cap_valid", k, o.capv, m_capv[k]);
         check("cap_x1", k, o.cx1, m_cx1[k]);
         check("cap_x2", k, o.cx2, m_cx2[k]);
         check("cap_b", k, o.cb, m_cb[k]);
         check("cap_a", k, o.ca, m_ca[k]);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] ra, input logic [31:0] rb, input logic st, input logic cl);
      int s;
      s = cyc % 32;
      hv[s] = v; hx1[s] = x1; hx2[s] = x2; hra[s] = ra; hrb[s] = rb;
      in_valid = v; in_x1 = x1; in_x2 = x2; start = st; clear = cl;
      for (int k = 0; k < ND; k++) begin
         res_a[k] = hra[(cyc - LA[k]) % 32];
         res_b[k] = hrb[(cyc - LB[k]) % 32];
         model_edge(k, st, cl);
      end
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
   endtask

   task automatic restart();
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      in_valid = 0; start = 0; clear = 0;
      #1 rstn = 1'b0;
      for (int i = 0; i < 32; i++) begin hv[i] = 0; hra[i] = 0; hrb[i] = 0; hx1[i] = 0; hx2[i] = 0; end
      for (int k = 0; k < ND; k++) model_clear(k);
      #1 check_all();
      @(posedge clk);
      #1;
      cyc++;
      rstn = 1'b1;
   endtask

   typedef struct {
      logic [31:0] a, b;
      int          mis_bit, mis_nan;
   } vec_t;

   vec_t        tbl [9];
   logic [31:0] r;
   logic [31:0] r2;

   initial begin
      tbl[0] = '{32'h3F800000, 32'h3F800000, 0, 0};
      tbl[1] = '{32'h3F000000, 32'h3F000001, 1, 1};
      tbl[2] = '{32'h7FC00000, 32'hFFC00001, 1, 0};
      tbl[3] = '{32'h7F800000, 32'h7FC00000, 1, 1};
      tbl[4] = '{32'h7F800000, 32'h7F800000, 0, 0};
      tbl[5] = '{32'h7F800001, 32'h7F800001, 0, 0};
      tbl[6] = '{32'hFF800001, 32'h7FFFFFFF, 1, 0};
      tbl[7] = '{32'h00000000, 32'h80000000, 1, 1};
      tbl[8] = '{32'h7F800000, 32'hFF800000, 1, 1};

      rstn = 1'b0; in_valid = 0; in_x1 = 0; in_x2 = 0; start = 0; clear = 0;
      for (int k = 0; k < ND; k++) begin res_a[k] = 0; res_b[k] = 0; model_clear(k); end
      for (int i = 0; i < 32; i++) begin hv[i] = 0; hra[i] = 0; hrb[i] = 0; hx1[i] = 0; hx2[i] = 0; end
      cyc = 32;
      #1 check_all();
      @(posedge clk); #1; cyc++;
      @(posedge clk); #1; cyc++;
      rstn = 1'b1;
      idle(3);

      // Single-op vectors: bitwise vs NaN-tolerant compare.
      for (int i = 0; i < 9; i++) begin
         restart();
         step(1'b1, 32'h100 + i, 32'h200 + i, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
         idle(9);
         check("tbl_bitwise", 0, mis0, tbl[i].mis_bit);
         check("tbl_naneq", 1, mis1, tbl[i].mis_nan);
      end

      // Unequal latencies: compare lands at t+7, visible t+8.
      restart();
      step(1'b1, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000001, 1'b0, 1'b0);
      idle(6);
      check("skew_err_early", 1, err1, 0);
      idle(1);
      check("skew_err", 1, err1, 1);
      check("skew_cap_x1", 1, cx1_1, 32'h3F800000);
      check("skew_cap_x2", 1, cx2_1, 32'h40000000);
      check("skew_cap_b", 1, cb1, 32'h3F000001);
      check("skew_cap_a", 1, ca1, 32'h3F000000);

      // Stop on first error: issues 5 and 9 disagree.
      restart();
      for (int i = 1; i <= 12; i++) begin
         r = $urandom;
         step(1'b1, 32'(i * 16), 32'(i), r, (i == 5 || i == 9) ? (r ^ 32'h1) : r, 1'b0, 1'b0);
      end
      idle(10);
      check("halt_running", 2, run2, 0);
      check("halt_check_cnt", 2, chk2, 5);
      check("halt_mismatch_cnt", 2, mis2, 1);
      check("halt_cap_x1", 2, cx1_2, 32'h50);
      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      check("halt_restart", 2, run2, 1);

      // Saturation on the 4-bit counters, then clear beating start.
      restart();
      for (int i = 1; i <= 20; i++) step(1'b1, 32'(100 + i), 32'(i), 32'(i), ~32'(i), 1'b0, 1'b0);
      idle(5);
      check("sat_mismatch_cnt", 3, mis3, 15);
      check("sat_check_cnt", 3, chk3, 15);
      check("sat_cap_x1", 3, cx1_3, 101);
      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
      check("clr_running", 3, run3, 0);
      check("clr_mismatch_cnt", 3, mis3, 0);
      check("clr_err", 3, err3, 0);
      check("clr_cap_valid", 3, capv3, 0);

      // 100 agreeing ops.
      restart();
      for (int i = 0; i < 100; i++) begin
         r = $urandom;
         step(1'b1, $urandom, $urandom, r, r, 1'b0, 1'b0);
      end
      idle(10);
      check("clean_check_cnt", 0, chk0, 100);
      check("clean_mismatch_cnt", 0, mis0, 0);
      check("clean_err", 0, err0, 0);

      // Reset with ops in flight; none may be compared afterwards.
      restart();
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, 32'h1, 32'h2, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
      idle(10);
      check("flight_check_cnt", 0, chk0, 0);
      check("flight_mismatch_cnt", 0, mis0, 0);

      // Random traffic with occasional NaN pairs, starts, clears and resets.
      for (int i = 0; i < 1500; i++) begin
         r = $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : r;
         if ($urandom_range(0, 7) == 0) begin
            r  = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
            r2 = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
         end
         if ($urandom_range(0, 399) == 0) do_reset();
         step(1'($urandom_range(0, 1)), $urandom, $urandom, r, r2,
              $urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0);
      end
      idle(10);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/fpu_lockstep_checker.md
FPU_LOCKSTEP_CHECKER -- requirements
Module: fpu_lockstep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter EXP_W, default 8, exponent field width (mantissa = WIDTH-1-EXP_W).
REQ-003 SHALL have parameter LAT_A, default 7, pipeline latency of unit A (new unit), range 0..31.
REQ-004 SHALL have parameter LAT_B, default 7, pipeline latency of unit B (reference unit), range 0..31.
REQ-005 SHALL have parameter NAN_EQ, default 0; 1 = any two NaNs compare equal.
REQ-006 SHALL have parameter STOP_ON_ERR, default 0; 1 = halt checking on first mismatch.
REQ-007 SHALL have parameter CNT_W, default 16, counter width.
REQ-008 clk  input  1  single clock, all state on rising edge.
REQ-009 rstn  input  1  asynchronous, active-low reset.
REQ-010 in_valid  input  1  operand pair issued to both units this cycle.
REQ-011 in_x1, in_x2  input  WIDTH  operands issued to both units.
REQ-012 res_a  input  WIDTH  unit A result, valid LAT_A cycles after issue.
REQ-013 res_b  input  WIDTH  unit B result, valid LAT_B cycles after issue.
REQ-014 start  input  1  enter RUN.
REQ-015 clear  input  1  return to IDLE, clear counters, capture and err.
REQ-016 running  output  1  state is RUN.
REQ-017 err  output  1  sticky: at least one mismatch since last clear.
REQ-018 check_cnt, mismatch_cnt  output  CNT_W  compares performed / mismatches found.
REQ-019 cap_valid  output  1  capture registers hold first mismatch.
REQ-020 cap_x1, cap_x2, cap_b, cap_a  output  WIDTH  operands, expected (B), actual (A) of first mismatch.

Function
REQ-021 LMAX = max(LAT_A, LAT_B); in_valid, in_x1, in_x2 SHALL be delayed LMAX cycles; res_a delayed LMAX-LAT_A, res_b delayed LMAX-LAT_B.
REQ-022 Delay lines SHALL shift every cycle regardless of state; zero-length delay is a wire.
REQ-023 Operation issued at cycle t SHALL be compared in cycle t+LMAX; counters/capture/err updated at that cycle's closing edge, visible cycle t+LMAX+1.
REQ-024 Compare SHALL occur only when delayed valid = 1 and state = RUN.
REQ-025 Mismatch: delayed res_a != delayed res_b bitwise; with NAN_EQ=1, both NaN (exp all ones, mantissa nonzero) SHALL count as match regardless of sign/payload.
REQ-026 Each compare SHALL increment check_cnt; each mismatch SHALL increment mismatch_cnt; both saturate at all-ones.
REQ-027 First mismatch after clear/reset SHALL load cap_* and set cap_valid; later mismatches SHALL NOT overwrite.
REQ-028 err SHALL set on any mismatch and hold until clear or reset.
REQ-029 States IDLE, RUN, HALT: IDLE->RUN on start; RUN->HALT on mismatch when STOP_ON_ERR=1; HALT->RUN on start; any->IDLE on clear.
REQ-030 clear SHALL take priority over start and over a same-cycle mismatch (mismatch discarded).
REQ-031 The compare causing RUN->HALT SHALL itself be counted and captured; none afterwards until start.
REQ-032 start while in RUN SHALL have no effect.

Reset
REQ-033 rstn low SHALL asynchronously force state IDLE, counters 0, err 0, cap_valid 0, cap_* 0, delay-line valid bits 0.
REQ-034 Delay-line data bits SHALL also reset to 0.
REQ-035 Operations in flight at reset SHALL never be compared.

Structure
REQ-036 Shared package fpu_check_pkg SHALL hold the state enum (IDLE, RUN, HALT) and an is_nan function parameterised by EXP_W.
REQ-037 Sub-module chk_delay (params WIDTH, DEPTH, async active-low reset) SHALL implement every delay line.

Verification
REQ-038 LAT_A=LAT_B=7, start, 100 issues with res_a=res_b -> check_cnt=100, mismatch_cnt=0, err=0.
REQ-039 LAT_A=3, LAT_B=7, x1=0x3F800000, x2=0x40000000, res_a=0x3F000000 at t+3, res_b=0x3F000001 at t+7 -> err=1 at t+8, cap_x1/x2 match, cap_b=0x3F000001, cap_a=0x3F000000.
REQ-040 NAN_EQ=1, res_a=0x7FC00000, res_b=0xFFC00001 -> no mismatch; NAN_EQ=0 -> mismatch_cnt=1.
REQ-041 STOP_ON_ERR=1, mismatches on issues 5 and 9 -> HALT after 5, check_cnt=5, mismatch_cnt=1, cap from issue 5.
REQ-042 CNT_W=4, 20 mismatching issues -> mismatch_cnt=15, cap from first; then clear with start same cycle -> IDLE, all cleared.
REQ-043 rstn low mid-stream with 4 ops in flight, then start -> no compares for those ops, check_cnt=0.
